mem_copy: RTL and testbench

MEM_COPY -- requirements
Module: mem_copy

---
 rtl/mem_copy_pkg.sv | 42 ++++
 rtl/mem_copy.sv | 123 ++++++++++++
 tb/tb_mem_copy.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// configure: shared bus record types for the mem_copy block.
//   mem_in_type     - request towards a memory (valid, instr, addr, wdata, wstrb)
//   mem_out_type    - response from a memory (rdata, error, ready)
//   copy_state_type - mem_copy FSM states
//   copy_reg_type   - mem_copy working registers (word addresses, count, data)
package configure;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } copy_state_type;

    // Addresses are kept as word addresses so +1 wraps modulo 2^32 bytes.
    typedef struct packed {
        logic [29:0] src;
        logic [29:0] dst;
        logic [15:0] cnt;
        logic [31:0] data;
    } copy_reg_type;

    // Expand a word address into a byte address.
    function automatic logic [31:0] word_to_byte(input logic [29:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/mem_copy.sv
// mem_copy: copies 'count' 32-bit words from a source memory interface to a
// destination memory interface, one word at a time (read, then write).
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   start                 - one-cycle copy request, honoured only in IDLE
//   src_addr, dst_addr    - byte start addresses (bits [1:0] ignored)
//   count                 - number of words to copy
//   src_in / src_out      - source responder / request
//   dst_in / dst_out      - destination responder / request
//   busy, done, error     - status: busy in RD/WR/DONE, done pulse, sticky abort
module mem_copy
    import configure::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] count,
    input  mem_out_type src_in,
    output mem_in_type  src_out,
    input  mem_out_type dst_in,
    output mem_in_type  dst_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    copy_state_type state_q, state_d;
    copy_reg_type   rec_q, rec_d;
    logic           err_q, err_d;
    // Request valid of the previous cycle; a ready only counts if the request
    // was already visible to the responder, so stale readies are dropped.
    logic           src_vprev_q;
    logic           dst_vprev_q;

    logic unused_inputs_s;
    assign unused_inputs_s = ^{dst_in.mem_rdata, src_addr[1:0], dst_addr[1:0]};

    // State, working record and handshake history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            err_q       <= 1'b0;
            src_vprev_q <= 1'b0;
            dst_vprev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            err_q       <= err_d;
            src_vprev_q <= src_out.mem_valid;
            dst_vprev_q <= dst_out.mem_valid;
        end
    end

    // Next-state, record update and request decode.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        err_d   = err_q;
        src_out = '0;
        dst_out = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rec_d.src = src_addr[31:2];
                    rec_d.dst = dst_addr[31:2];
                    rec_d.cnt = count;
                    err_d     = 1'b0;
                    state_d   = (count == 16'd0) ? DONE : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                src_out.mem_valid = 1'b1;
                src_out.mem_addr  = word_to_byte(rec_q.src);
                if (src_in.mem_ready && src_vprev_q) begin
                    if (src_in.mem_error) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rec_d.data = src_in.mem_rdata;
                        state_d    = WR;
                    end
                end else begin
                    state_d = RD;
                end
            end
            WR: begin
                dst_out.mem_valid = 1'b1;
                dst_out.mem_addr  = word_to_byte(rec_q.dst);
                dst_out.mem_wdata = rec_q.data;
                dst_out.mem_wstrb = 4'hF;
                if (dst_in.mem_ready && dst_vprev_q) begin
                    if (dst_in.mem_error) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rec_d.src = rec_q.src + 30'd1;
                        rec_d.dst = rec_q.dst + 30'd1;
                        rec_d.cnt = rec_q.cnt - 16'd1;
                        state_d   = (rec_q.cnt == 16'd1) ? DONE : RD;
                    end
                end else begin
                    state_d = WR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign error = err_q;

endmodule

// File: tb/tb_mem_copy.sv
module tb_mem_copy;
    import configure::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [15:0] count = 16'd0;
    mem_out_type src_in, dst_in;
    mem_in_type  src_out, dst_out;
    logic        busy, done, error;

    mem_copy dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
        .src_in(src_in), .src_out(src_out),
        .dst_in(dst_in), .dst_out(dst_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // ---------------- responder models and monitors ----------------
    logic [31:0] rom [16];
    logic        src_ready = 1'b0, src_err = 1'b0, src_vprev = 1'b0;
    logic [31:0] src_rdata = 32'd0;
    logic        dst_ready = 1'b0, dst_vprev = 1'b0;
    int          dst_wcnt = 0;
    int          dst_wait = 0;
    logic        err_en = 1'b0;
    int          err_idx = 0;
    int          rd_base = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wa[$], wd[$];
    logic [3:0]  ws[$];
    mem_in_type  src_prev = '0, dst_prev = '0;
    int stab_err = 0, overlap = 0, fld_err = 0, valid_cyc = 0, done_cnt = 0;

    assign src_in = '{mem_rdata: src_rdata, mem_error: src_err, mem_ready: src_ready};
    assign dst_in = '{mem_rdata: 32'h0, mem_error: 1'b0, mem_ready: dst_ready};

    always @(posedge clock) begin
        src_ready <= src_out.mem_valid && !src_ready;
        src_rdata <= rom[src_out.mem_addr[5:2]];
        src_err   <= err_en && ((rd_log.size() - rd_base) == err_idx);
        if (dst_out.mem_valid && !dst_ready) begin
            if (dst_wcnt == dst_wait) begin
                dst_ready <= 1'b1;
                dst_wcnt  <= 0;
            end else begin
                dst_wcnt <= dst_wcnt + 1;
            end
        end else begin
            dst_ready <= 1'b0;
            dst_wcnt  <= 0;
        end
        if (src_ready && src_out.mem_valid && src_vprev) rd_log.push_back(src_out.mem_addr);
        if (dst_ready && dst_out.mem_valid && dst_vprev) begin
            wa.push_back(dst_out.mem_addr);
            wd.push_back(dst_out.mem_wdata);
            ws.push_back(dst_out.mem_wstrb);
        end
        if (src_prev.mem_valid && src_out.mem_valid && src_prev != src_out) stab_err <= stab_err + 1;
        if (dst_prev.mem_valid && dst_out.mem_valid && dst_prev != dst_out) stab_err <= stab_err + 1;
        if (src_out.mem_valid && dst_out.mem_valid) overlap <= overlap + 1;
        if (src_out.mem_valid || dst_out.mem_valid) valid_cyc <= valid_cyc + 1;
        if (src_out.mem_valid && (src_out.mem_wstrb != 4'h0 || src_out.mem_wdata != 32'h0 || src_out.mem_instr))
            fld_err <= fld_err + 1;
        if (dst_out.mem_valid && (dst_out.mem_wstrb != 4'hF || dst_out.mem_instr))
            fld_err <= fld_err + 1;
        if (done) done_cnt <= done_cnt + 1;
        src_vprev <= src_out.mem_valid;
        dst_vprev <= dst_out.mem_valid;
        src_prev  <= src_out;
        dst_prev  <= dst_out;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] src;
        logic [31:0] dst;
        logic        err_en;
        int          err_idx;
        int          dwait;
        logic        restart;
        int          lat;
        logic        exp_err;
        int          reads;
        int          writes;
    } vec_t;

    task automatic run_copy(input string tag, input vec_t v);
        int n, nb, rb, wb, db, vb, nr, nw;
        logic [31:0] ea;
        logic [3:0]  ri;
        rb = rd_log.size(); wb = wa.size(); db = done_cnt; vb = valid_cyc;
        rd_base = rb; err_en = v.err_en; err_idx = v.err_idx; dst_wait = v.dwait;
        @(negedge clock);
        src_addr = v.src; dst_addr = v.dst; count = v.cnt; start = 1'b1;
        n = 0; nb = 0;
        @(negedge clock);
        n = 1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, " error_cleared"}, {31'd0, error}, 32'd0);
        while (!done && n < 300) begin
            if (busy) nb++;
            @(negedge clock);
            n++;
            if (v.restart && n == 3) begin
                start = 1'b1; count = 16'd9; src_addr = 32'h40; dst_addr = 32'h9000;
            end else begin
                start = 1'b0;
            end
        end
        if (busy) nb++;
        chk({tag, " done_latency"}, n, v.lat);
        chk({tag, " busy_cycles"}, nb, v.lat);
        chk({tag, " error_flag"}, {31'd0, error}, {31'd0, v.exp_err});
        @(negedge clock);
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " busy_dropped"}, {31'd0, busy}, 32'd0);
        chk({tag, " done_pulses"}, done_cnt - db, 32'd1);
        nr = rd_log.size() - rb;
        nw = wa.size() - wb;
        chk({tag, " read_count"}, nr, v.reads);
        chk({tag, " write_count"}, nw, v.writes);
        for (int i = 0; i < v.reads && i < nr; i++) begin
            ea = v.src + 32'(4 * i);
            chk($sformatf("%s rd_addr[%0d]", tag, i), rd_log[rb + i], ea);
        end
        for (int i = 0; i < v.writes && i < nw; i++) begin
            ea = v.dst + 32'(4 * i);
            ri = v.src[5:2] + 4'(i);
            chk($sformatf("%s wr_addr[%0d]", tag, i), wa[wb + i], ea);
            chk($sformatf("%s wr_data[%0d]", tag, i), wd[wb + i], rom[ri]);
            chk($sformatf("%s wr_strb[%0d]", tag, i), {28'd0, ws[wb + i]}, 32'hF);
        end
        if (v.cnt == 16'd0) chk({tag, " no_valid"}, valid_cyc - vb, 32'd0);
    endtask

    vec_t vecs[6];
    vec_t post;
    int   dc;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'hA5A50000 | 32'(i);
        rom[0]  = 32'h41014081;
        rom[1]  = 32'h42014181;
        rom[2]  = 32'h43014281;
        rom[15] = 32'hCAFEF00D;
        //          cnt    src           dst          ee    ei dw rs    lat ee    rd wr
        vecs[0] = '{16'd3, 32'h0,        32'h1000,    1'b0, 0, 0, 1'b0, 13, 1'b0, 3, 3};
        vecs[1] = '{16'd0, 32'h20,       32'h2000,    1'b0, 0, 0, 1'b0, 1,  1'b0, 0, 0};
        vecs[2] = '{16'd2, 32'hFFFFFFFC, 32'h3000,    1'b0, 0, 0, 1'b0, 9,  1'b0, 2, 2};
        vecs[3] = '{16'd4, 32'h10,       32'h4000,    1'b1, 2, 0, 1'b0, 11, 1'b1, 3, 2};
        vecs[4] = '{16'd1, 32'h8,        32'h5000,    1'b0, 0, 0, 1'b0, 5,  1'b0, 1, 1};
        vecs[5] = '{16'd2, 32'h4,        32'h6000,    1'b0, 0, 3, 1'b1, 15, 1'b0, 2, 2};
        post    = '{16'd1, 32'h24,       32'h8000,    1'b0, 0, 0, 1'b0, 5,  1'b0, 1, 1};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset error", {31'd0, error}, 32'd0);
        chk("reset src_out", 32'(src_out != '0), 32'd0);
        chk("reset dst_out", 32'(dst_out != '0), 32'd0);

        for (int k = 0; k < 6; k++) run_copy($sformatf("vec%0d", k), vecs[k]);

        // Reset while writing word 2 of a 5-word copy.
        err_en = 1'b0; dst_wait = 0;
        @(negedge clock);
        src_addr = 32'h0; dst_addr = 32'h7000; count = 16'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("midreset in_wr", {31'd0, dst_out.mem_valid}, 32'd1);
        chk("midreset wr_addr", dst_out.mem_addr, 32'h7004);
        dc = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset src_valid", {31'd0, src_out.mem_valid}, 32'd0);
        chk("midreset dst_valid", {31'd0, dst_out.mem_valid}, 32'd0);
        repeat (10) @(negedge clock);
        chk("midreset no_done", done_cnt - dc, 32'd0);
        chk("midreset still_idle", {31'd0, busy}, 32'd0);
        run_copy("postreset", post);

        chk("stable_requests", stab_err, 32'd0);
        chk("no_overlap", overlap, 32'd0);
        chk("request_fields", fld_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
